ofifo: RTL and testbench
========================

OFIFO -- requirements
Module: ofifo

Interface
REQ-001 SHALL have parameter psum_bw, default 16, meaning the bit width of one column psum.
REQ-002 SHALL have parameter col, default 8, meaning the number of mac array columns.
REQ-003 SHALL have parameter depth, default 16, meaning the entries per column queue (power of two).
REQ-004 SHALL have port clk, input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, width 1, meaning a synchronous, active-high reset.
REQ-006 SHALL have port in, input, width psum_bw*col, meaning the mac array out_s bus; column c is in[psum_bw*(c+1)-1:psum_bw*c].
REQ-007 SHALL have port wr, input, width col, meaning the per-column write strobe, driven by the mac array valid.
REQ-008 SHALL have port rd, input, width 1, meaning a request to pop one full row.
REQ-009 SHALL have port out, output, width psum_bw*col, meaning the registered popped row, in the same column packing as in.
REQ-010 SHALL have port o_out_valid, output, width 1, meaning out holds newly popped data this cycle.
REQ-011 SHALL have port o_full, output, width 1, meaning at least one column queue is full.
REQ-012 SHALL have port o_ready, output, width 1, meaning no column queue is full (~o_full).
REQ-013 SHALL have port o_valid, output, width 1, meaning every column queue is non-empty.
REQ-014 SHALL have port o_overflow, output, width 1, meaning sticky: a write was dropped.

Function
REQ-015 SHALL keep one independent circular queue per column, with log2(depth)+1-bit read and write pointers (MSB is the wrap bit).
- Empty: pointers are equal.
- Full: low bits are equal and wrap bits differ.
REQ-016 SHALL write in column c on wr[c] in the same edge when the column is not full, or when a row pop is accepted in that cycle.
REQ-017 SHALL drop a write to a full column with no pop in that cycle, leave that column's pointers unchanged, and set o_overflow.
REQ-018 SHALL accept a pop only when rd=1 and o_valid=1. An accepted pop advances all col read pointers together.
REQ-019 SHALL ignore rd while o_valid=0: no pointer change, and o_out_valid=0 next cycle.
REQ-020 SHALL load out with the head entry of every column one cycle after an accepted pop, with o_out_valid=1 for exactly that cycle. out SHALL hold its value otherwise.
REQ-021 SHALL handle a simultaneous write and accepted pop on one column by doing both, leaving its occupancy unchanged.
- There is no empty-queue bypass: a word written at edge N is poppable at edge N+1 at the earliest.
REQ-022 SHALL derive o_full, o_ready and o_valid combinationally from the current pointers only; they SHALL NOT depend on wr or rd.
REQ-023 SHALL wrap pointers modulo 2*depth with no special-case logic at the depth boundary.
REQ-024 SHALL store psum data as-is, with no sign extension or truncation.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, clear all pointers, clear out to 0, and clear o_out_valid and o_overflow. Queue storage contents are don't-care.
REQ-026 SHALL, after reset, have o_valid=0, o_full=0 and o_ready=1.
REQ-027 SHALL let reset asserted mid-operation override any same-cycle wr or rd; all queued data is discarded.

Structure
REQ-028 SHALL take the default values of psum_bw and col from the shared accelerator parameter package, alongside the mac array's. depth SHALL be a local parameter override.
REQ-029 SHALL use one sub-module, ofifo_col (a single-column queue with wr, rd, data and empty/full flags), instantiated col times in a generate loop.
REQ-030 SHALL build the top-level flags as reductions: o_valid = AND of not-empty; o_full = OR of full.

Verification
REQ-031 SHALL include a skewed fill:
- Stimulus: wr asserts column c at cycle c, col=8, with in column c = 0x0100+c.
- Response: o_valid rises only after the column 7 write; rd then gives out = {0x0107..0x0100} with o_out_valid=1 for one cycle, and o_valid then returns to 0.
REQ-032 SHALL include a full boundary: 16 writes on all columns give o_full=1 and o_ready=0; a 17th write with rd=0 sets o_overflow=1 and a later pop returns the first row, not the 17th.
REQ-033 SHALL include write-and-pop at full: with all columns full, wr=0xFF and rd=1 together give 16 occupancy, o_full stays 1, and o_overflow stays 0.
REQ-034 SHALL include wrap-around: 40 sequential rows with interleaved pops return data in order, covering pointer wrap twice.
REQ-035 SHALL include rd while empty: rd=1 with only column 3 written gives no pop, o_out_valid=0 and out unchanged.
REQ-036 SHALL include mid-operation reset: reset=1 with 5 rows queued and wr=0xFF, rd=1 in the same cycle gives next-cycle o_valid=0, o_overflow=0, out=0 and o_out_valid=0.

Source files
------------

// File: rtl/ofifo_pkg.sv
// Shared accelerator parameters: MAC array geometry and psum width used by
// the MAC array and the output FIFO, plus a small pointer-width helper.
package ofifo_pkg;
    localparam int PSUM_BW  = 16;
    localparam int COL      = 8;
    localparam int MAC_ROW  = 8;
    localparam int ACT_BW   = 4;
    localparam int WGT_BW   = 4;

    // Queue pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/ofifo_col.sv
// Single-column circular queue. Pointers carry an extra wrap bit so that
// empty (pointers equal) and full (index equal, wrap differs) are distinct.
// The head entry is presented combinationally on data_o.
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_i,
    input  logic               rd_i,
    input  logic [psum_bw-1:0] data_i,
    output logic [psum_bw-1:0] data_o,
    output logic               empty_o,
    output logic               full_o,
    output logic               drop_o
);
    localparam int AW = $clog2(depth);
    localparam int PW = ptr_w(depth);

    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [psum_bw-1:0] mem_q [depth];
    logic               wr_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    // A pop in the same cycle frees the slot, so a write to a full queue is
    // still accepted then; otherwise it is dropped.
    assign wr_ok   = wr_i && (!full_o || rd_i);
    assign drop_o  = wr_i && full_o && !rd_i;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // Next pointers: natural modulo-2*depth increment, no boundary special case.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_ok) wptr_d = wptr_q + PW'(1);
        if (rd_i)  rptr_d = rptr_q + PW'(1);
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/ofifo.sv
// Output FIFO behind the MAC array: one queue per column, filled
// independently by the column valid strobes and drained a full row at a time.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_out_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic                   o_overflow
);
    logic [psum_bw*col-1:0] heads;
    logic [col-1:0]         empty_v;
    logic [col-1:0]         full_v;
    logic [col-1:0]         drop_v;
    logic                   pop;

    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overflow_q, overflow_d;

    for (genvar g = 0; g < col; g++) begin : g_col
        ofifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk     (clk),
            .reset   (reset),
            .wr_i    (wr[g]),
            .rd_i    (pop),
            .data_i  (in[psum_bw*g +: psum_bw]),
            .data_o  (heads[psum_bw*g +: psum_bw]),
            .empty_o (empty_v[g]),
            .full_o  (full_v[g]),
            .drop_o  (drop_v[g])
        );
    end

    // Flags come from pointers only; a row is poppable once every column has data.
    assign o_valid = &(~empty_v);
    assign o_full  = |full_v;
    assign o_ready = ~o_full;
    assign pop     = rd && o_valid;

    // Output row capture, one-cycle valid pulse and sticky overflow.
    always_comb begin
        out_d       = out_q;
        out_valid_d = pop;
        overflow_d  = overflow_q || (|drop_v);
        if (pop) out_d = heads;
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out         = out_q;
    assign o_out_valid = out_valid_q;
    assign o_overflow  = overflow_q;
endmodule

// File: tb/tb_ofifo.sv
// Bench for ofifo: a queue-per-column reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ofifo;
    localparam int PB    = 16;
    localparam int NC    = 8;
    localparam int DEPTH = 16;
    localparam int W     = PB * NC;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [W-1:0]   in = '0;
    logic [NC-1:0]  wr = '0;
    logic           rd = 1'b0;
    logic [W-1:0]   out;
    logic           o_out_valid, o_full, o_ready, o_valid, o_overflow;

    int checks = 0;
    int errors = 0;

    ofifo #(.psum_bw(PB), .col(NC), .depth(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .wr          (wr),
        .rd          (rd),
        .out         (out),
        .o_out_valid (o_out_valid),
        .o_full      (o_full),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues per column.
    logic [PB-1:0] q [NC][$];
    logic [W-1:0]  exp_out = '0;
    logic          exp_ov  = 1'b0;
    logic          exp_ovf = 1'b0;
    bit            armed   = 1'b0;
    int            msz [NC];
    bit            m_all;
    bit            m_pop;

    always @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NC; c++) q[c].delete();
            exp_out = '0;
            exp_ov  = 1'b0;
            exp_ovf = 1'b0;
            armed   = 1'b1;
        end else begin
            m_all = 1'b1;
            for (int c = 0; c < NC; c++) begin
                msz[c] = q[c].size();
                if (msz[c] == 0) m_all = 1'b0;
            end
            m_pop = rd && m_all;
            exp_ov = m_pop;
            if (m_pop)
                for (int c = 0; c < NC; c++) exp_out[PB*c +: PB] = q[c].pop_front();
            for (int c = 0; c < NC; c++) begin
                if (wr[c]) begin
                    if (msz[c] < DEPTH || m_pop) q[c].push_back(in[PB*c +: PB]);
                    else exp_ovf = 1'b1;
                end
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    logic e_valid, e_full;
    always @(negedge clk) begin
        if (armed) begin
            e_valid = 1'b1;
            e_full  = 1'b0;
            for (int c = 0; c < NC; c++) begin
                if (q[c].size() == 0)     e_valid = 1'b0;
                if (q[c].size() == DEPTH) e_full  = 1'b1;
            end
            chkw("m_out", out, exp_out);
            chk1("m_out_valid", o_out_valid, exp_ov);
            chk1("m_overflow", o_overflow, exp_ovf);
            chk1("m_valid", o_valid, e_valid);
            chk1("m_full", o_full, e_full);
            chk1("m_ready", o_ready, ~e_full);
        end
    end

    // One clock cycle of stimulus; inputs return idle just after the edge.
    task automatic cyc(input logic r, input logic [NC-1:0] w, input logic [W-1:0] d, input logic p);
        @(negedge clk);
        reset = r;
        wr    = w;
        in    = d;
        rd    = p;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
    endtask

    function automatic logic [W-1:0] row_val(input int k);
        logic [W-1:0] v;
        for (int c = 0; c < NC; c++) v[PB*c +: PB] = 16'(16'h1000 + k * 16 + c);
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [W-1:0] skew;
    logic [W-1:0] lit;
    logic [NC-1:0] rw;

    initial begin
        // Reset state.
        cyc(1'b1, '0, '0, 1'b0);
        chk1("rst_valid", o_valid, 1'b0);
        chk1("rst_full", o_full, 1'b0);
        chk1("rst_ready", o_ready, 1'b1);
        chkw("rst_out", out, '0);

        // Skewed fill: column c written at cycle c.
        for (int k = 0; k < NC; k++) skew[PB*k +: PB] = 16'(16'h0100 + k);
        for (int c = 0; c < NC; c++) begin
            cyc(1'b0, NC'(1) << c, skew, 1'b0);
            chk1("skew_valid", o_valid, (c == NC - 1));
        end
        cyc(1'b0, '0, '0, 1'b1);
        lit = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
        chkw("skew_out", out, lit);
        chk1("skew_ov", o_out_valid, 1'b1);
        chk1("skew_valid_after", o_valid, 1'b0);
        cyc(1'b0, '0, '0, 1'b0);
        chk1("skew_ov_pulse", o_out_valid, 1'b0);

        // Full boundary and overflow drop.
        cyc(1'b1, '0, '0, 1'b0);
        for (int k = 0; k < DEPTH; k++) cyc(1'b0, '1, row_val(k), 1'b0);
        chk1("full_full", o_full, 1'b1);
        chk1("full_ready", o_ready, 1'b0);
        chk1("full_ovf0", o_overflow, 1'b0);
        cyc(1'b0, '1, row_val(DEPTH), 1'b0);
        chk1("full_ovf1", o_overflow, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        lit = 128'h1007_1006_1005_1004_1003_1002_1001_1000;
        chkw("full_first_row", out, lit);

        // Write and pop together while full.
        cyc(1'b1, '0, '0, 1'b0);
        for (int k = 0; k < DEPTH; k++) cyc(1'b0, '1, row_val(k), 1'b0);
        cyc(1'b0, '1, row_val(DEPTH), 1'b1);
        chk1("wp_full", o_full, 1'b1);
        chk1("wp_ovf", o_overflow, 1'b0);
        chkw("wp_out", out, lit);

        // Wrap-around: 40 rows with interleaved pops.
        cyc(1'b1, '0, '0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, '1, row_val(k), 1'b0);
            if (k % 2 == 1) begin
                cyc(1'b0, '0, '0, 1'b1);
                chkw("wrap_out", out, row_val(k - 1));
                cyc(1'b0, '0, '0, 1'b1);
                chkw("wrap_out2", out, row_val(k));
            end
        end

        // rd while not every column holds data.
        cyc(1'b0, 8'h08, rnd_row(), 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        chk1("empty_rd_ov", o_out_valid, 1'b0);
        chkw("empty_rd_out", out, row_val(39));

        // Mid-operation reset overrides same-cycle wr and rd.
        cyc(1'b1, '0, '0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, '1, rnd_row(), 1'b0);
        cyc(1'b1, '1, rnd_row(), 1'b1);
        chk1("mrst_valid", o_valid, 1'b0);
        chk1("mrst_ovf", o_overflow, 1'b0);
        chkw("mrst_out", out, '0);
        chk1("mrst_ov", o_out_valid, 1'b0);

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NC; c++) rw[c] = ($urandom_range(0, 9) < 6);
            cyc(($urandom_range(0, 199) == 0), rw, rnd_row(), $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
